instruction_fifo: RTL and testbench

INSTRUCTION_FIFO -- requirements
Module: instruction_fifo

---
 rtl/instruction_fifo.sv | 128 ++++++++++++
 tb/tb_instruction_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fifo.sv
// instruction_fifo: circular-buffer FIFO that accepts up to four entries per
// write and returns one registered entry per read.
//
// Parameters
//   LINE  - entry width in bits
//   DEPTH - entry count (power of two, >= 8)
//   SOON  - threshold for full_soon / empty_soon (1 .. DEPTH/2)
//
// Ports
//   clk                    single clock, rising edge
//   reset                  asynchronous active-low reset
//   re                     pop one entry
//   we, we_count           push we_count+1 entries (all or nothing)
//   dat_w_1 .. dat_w_4     write entries, dat_w_1 oldest
//   dat_r, dat_r_valid     registered read data, valid for one cycle per pop
//   count                  current occupancy
//   full_soon, empty_soon  occupancy thresholds
//   empty                  count == 0
//   overflow, underflow    sticky error flags, cleared only by reset
module instruction_fifo #(
  parameter int unsigned LINE  = 22,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned SOON  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       re,
  input  logic                       we,
  input  logic [1:0]                 we_count,
  input  logic [LINE-1:0]            dat_w_1,
  input  logic [LINE-1:0]            dat_w_2,
  input  logic [LINE-1:0]            dat_w_3,
  input  logic [LINE-1:0]            dat_w_4,
  output logic [LINE-1:0]            dat_r,
  output logic                       dat_r_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full_soon,
  output logic                       empty_soon,
  output logic                       empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] SoonC  = CW'(SOON);

  logic [LINE-1:0] mem [DEPTH];
  logic [LINE-1:0] dat_w [4];

  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [LINE-1:0] dat_r_q, dat_r_d;
  logic            dat_r_valid_q, dat_r_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic            pop;
  logic            push_ok;
  logic [CW-1:0]   wr_num;
  logic [CW-1:0]   free_slots;

  always_comb begin
    dat_w[0] = dat_w_1;
    dat_w[1] = dat_w_2;
    dat_w[2] = dat_w_3;
    dat_w[3] = dat_w_4;
  end

  always_comb begin
    pop        = re && (count_q != '0);
    wr_num     = {{(CW-2){1'b0}}, we_count} + CW'(1);
    // A pop on the same edge frees a slot for the write.
    free_slots = DepthC - count_q + {{(CW-1){1'b0}}, pop};
    push_ok    = we && (free_slots >= wr_num);

    rptr_d        = pop ? rptr_q + AW'(1) : rptr_q;
    wptr_d        = push_ok ? wptr_q + wr_num[AW-1:0] : wptr_q;
    count_d       = count_q - {{(CW-1){1'b0}}, pop} + (push_ok ? wr_num : '0);
    dat_r_d       = pop ? mem[rptr_q] : dat_r_q;
    dat_r_valid_d = pop;
    overflow_d    = overflow_q | (we && !push_ok);
    underflow_d   = underflow_q | (re && !pop);
  end

  // Storage is not reset; unwritten locations are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok && (i <= int'(we_count))) begin
        mem[wptr_q + AW'(i)] <= dat_w[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q        <= '0;
      wptr_q        <= '0;
      count_q       <= '0;
      dat_r_q       <= '0;
      dat_r_valid_q <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
      dat_r_q       <= dat_r_d;
      dat_r_valid_q <= dat_r_valid_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  always_comb begin
    dat_r       = dat_r_q;
    dat_r_valid = dat_r_valid_q;
    count       = count_q;
    empty       = (count_q == '0);
    empty_soon  = (count_q <= SoonC);
    full_soon   = ((DepthC - count_q) < SoonC);
    overflow    = overflow_q;
    underflow   = underflow_q;
  end

endmodule

// File: tb/tb_instruction_fifo.sv
// Self-checking bench for instruction_fifo (LINE=22, DEPTH=16, SOON=4).
// Stimulus pushes expected read data into a scoreboard queue; a monitor on the
// falling edge pops and compares whenever dat_r_valid is high.
module tb_instruction_fifo;

  logic        clk;
  logic        reset;
  logic        re;
  logic        we;
  logic [1:0]  we_count;
  logic [21:0] dat_w_1, dat_w_2, dat_w_3, dat_w_4;
  logic [21:0] dat_r;
  logic        dat_r_valid;
  logic [4:0]  count;
  logic        full_soon, empty_soon, empty, overflow, underflow;

  instruction_fifo #(.LINE(22), .DEPTH(16), .SOON(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .re          (re),
    .we          (we),
    .we_count    (we_count),
    .dat_w_1     (dat_w_1),
    .dat_w_2     (dat_w_2),
    .dat_w_3     (dat_w_3),
    .dat_w_4     (dat_w_4),
    .dat_r       (dat_r),
    .dat_r_valid (dat_r_valid),
    .count       (count),
    .full_soon   (full_soon),
    .empty_soon  (empty_soon),
    .empty       (empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [21:0] model_q [$];
  logic [21:0] exp_q   [$];
  bit          m_ovf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid read must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && dat_r_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(dat_r), 32'hdead);
      end else begin
        chk("read_data", 32'(dat_r), 32'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; the reference queue tracks what the FIFO should hold.
  task automatic cyc(input bit r, input bit w, input int wc, input int base);
    bit pop;
    int free_slots;
    re       = r;
    we       = w;
    we_count = wc[1:0];
    dat_w_1  = 22'(base);
    dat_w_2  = 22'(base + 1);
    dat_w_3  = 22'(base + 2);
    dat_w_4  = 22'(base + 3);
    pop        = r && (model_q.size() != 0);
    free_slots = 16 - model_q.size() + int'(pop);
    if (pop) exp_q.push_back(model_q.pop_front());
    if (w) begin
      if (free_slots >= wc + 1) begin
        for (int i = 0; i <= wc; i++) model_q.push_back(22'(base + i));
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    re = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; re = 1'b0; we = 1'b0; we_count = 2'd0;
    dat_w_1 = '0; dat_w_2 = '0; dat_w_3 = '0; dat_w_4 = '0;
    #12;
    chk("rst_count",      32'(count), 0);
    chk("rst_empty",      32'(empty), 1);
    chk("rst_empty_soon", 32'(empty_soon), 1);
    chk("rst_full_soon",  32'(full_soon), 0);
    chk("rst_dat_r",      32'(dat_r), 0);
    chk("rst_valid",      32'(dat_r_valid), 0);
    chk("rst_ovf",        32'(overflow), 0);
    chk("rst_unf",        32'(underflow), 0);
    @(negedge clk);
    reset = 1'b1;

    // Push 1,2,3,4 in one write, then four pops.
    cyc(0, 1, 3, 1);
    chk("push4_count", 32'(count), 4);
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
    chk("pop4_empty", 32'(empty), 1);
    chk("pop4_unf",   32'(underflow), 0);
    @(negedge clk);

    // Pop from empty: data held, valid low, sticky underflow.
    cyc(1, 0, 0, 0);
    chk("uf_flag",  32'(underflow), 1);
    chk("uf_valid", 32'(dat_r_valid), 0);
    chk("uf_dat_r", 32'(dat_r), 4);
    chk("uf_count", 32'(count), 0);

    // Fill to 16 with threshold checks, drop a write, then write+pop when full.
    cyc(0, 1, 3, 'h10);
    cyc(0, 1, 3, 'h14);
    cyc(0, 1, 3, 'h18);
    chk("c12_count",      32'(count), 12);
    chk("c12_full_soon",  32'(full_soon), 0);
    chk("c12_empty_soon", 32'(empty_soon), 0);
    cyc(0, 1, 0, 'h1c);
    chk("c13_full_soon", 32'(full_soon), 1);
    cyc(0, 1, 2, 'h1d);
    chk("full_count",     32'(count), 16);
    chk("full_full_soon", 32'(full_soon), 1);
    chk("full_ovf_clear", 32'(overflow), 0);
    cyc(0, 1, 0, 'h99);
    chk("drop_ovf",   32'(overflow), 1);
    chk("drop_count", 32'(count), 16);
    cyc(1, 1, 0, 'h20);
    chk("wrpop_count", 32'(count), 16);
    for (int k = 0; k < 16; k++) begin
      cyc(1, 0, 0, 0);
      chk("drain_count", 32'(count), 32'(15 - k));
      if (k == 10) chk("c5_empty_soon", 32'(empty_soon), 0);
      if (k == 11) chk("c4_empty_soon", 32'(empty_soon), 1);
    end

    // Wrap-around: push-2/pop-1 phases alternating with drain phases.
    for (int i = 0; i < 40; i++) begin
      if (((i / 8) % 2) == 0) cyc(1, 1, 1, 'h100 + 2 * i);
      else                    cyc(1, (i % 3) == 0, 0, 'h100 + 2 * i);
    end
    while (model_q.size() != 0) cyc(1, 0, 0, 0);
    chk("wrap_count", 32'(count), 0);
    chk("wrap_ovf",   32'(overflow), 32'(m_ovf));

    // Asynchronous reset mid-cycle with count=9 and a write presented.
    cyc(0, 1, 3, 'h200);
    cyc(0, 1, 3, 'h204);
    cyc(0, 1, 0, 'h208);
    chk("pre_rst_count", 32'(count), 9);
    @(negedge clk);
    #2;
    we = 1'b1; we_count = 2'd3;
    reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_dat_r", 32'(dat_r), 0);
    chk("arst_ovf",   32'(overflow), 0);
    chk("arst_unf",   32'(underflow), 0);
    model_q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("arst_hold_count", 32'(count), 0);
    we = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 1, 0, 7);
    cyc(1, 0, 0, 0);
    chk("post_rst_empty", 32'(empty), 1);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
